// File: rtl/elevator_scan_ctrl_pkg.sv
// Shared encodings for the SCAN elevator controller:
// display codes, FSM state encodings and defaults.
package elevator_scan_ctrl_pkg;

  localparam int F_N_DEF = 8;

  localparam logic [3:0] RS_IDLE = 4'd0;
  localparam logic [3:0] RS_UP   = 4'd1;
  localparam logic [3:0] RS_DOWN = 4'd2;

  localparam logic [3:0] DS_CLOSE = 4'd0;
  localparam logic [3:0] DS_OPEN  = 4'd1;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_DECIDE = 4'd1;
  localparam logic [3:0] ST_UP     = 4'd2;
  localparam logic [3:0] ST_DOWN   = 4'd3;
  localparam logic [3:0] ST_OPEN   = 4'd4;

  typedef enum logic [3:0] {
    S_IDLE   = ST_IDLE,
    S_DECIDE = ST_DECIDE,
    S_UP     = ST_UP,
    S_DOWN   = ST_DOWN,
    S_OPEN   = ST_OPEN
  } state_t;

endpackage

// File: rtl/elevator_scan_ctrl_scan_pick.sv
// SCAN helper: reports whether requests are pending at,
// above or below the current floor.
module scan_pick
  import elevator_scan_ctrl_pkg::*;
#(
  parameter int F_N = F_N_DEF,
  parameter int FW  = 4
) (
  input  logic [F_N-1:0] pending,
  input  logic [FW-1:0]  curr_floor,
  input  logic           dir,
  output logic           here,
  output logic           above,
  output logic           below
);

  // dir does not affect which requests exist, only
  // the caller's choice between them
  logic unused_dir;
  assign unused_dir = dir;

  always_comb begin
    here  = 1'b0;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < F_N; i++) begin
      if (i > int'(curr_floor))
        above = above | pending[i];
      if (i < int'(curr_floor))
        below = below | pending[i];
      if (i == int'(curr_floor))
        here = here | pending[i];
    end
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator controller: latched floor requests,
// direction-keeping travel, door and travel timers.
module elevator_scan_ctrl
  import elevator_scan_ctrl_pkg::*;
#(
  parameter int F_N       = F_N_DEF,
  parameter int FW        = 4,
  parameter int MOVE_TIME = 3,
  parameter int OPEN_TIME = 5,
  parameter int TW        = 4
) (
  input  logic           clk10hz,
  input  logic           rst,
  input  logic           tick1hz,
  input  logic [F_N-1:0] floor_req,
  input  logic           door_hold,
  input  logic           door_close,
  output logic [FW-1:0]  curr_floor,
  output logic [F_N-1:0] pending,
  output logic [3:0]     running_state,
  output logic [3:0]     door_state,
  output logic [3:0]     state
);

  localparam logic [FW-1:0] TOP = FW'(F_N - 1);
  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_TIME - 1);
  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_TIME - 1);

  state_t         state_q, state_n;
  logic [FW-1:0]  floor_n;
  logic [TW-1:0]  timer, timer_n;
  logic           dir, dir_n;
  logic [F_N-1:0] clr;
  logic [F_N-1:0] sel;
  logic           here, above, below;
  logic           req_here;

  scan_pick #(
    .F_N (F_N),
    .FW  (FW)
  ) u_pick (
    .pending    (pending),
    .curr_floor (curr_floor),
    .dir        (dir),
    .here       (here),
    .above      (above),
    .below      (below)
  );

  assign sel = {{(F_N-1){1'b0}}, 1'b1} << curr_floor;
  assign req_here = |(floor_req & sel);

  always_ff @(posedge clk10hz or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      curr_floor <= '0;
      pending    <= '0;
      dir        <= 1'b1;
      timer      <= '0;
    end else begin
      state_q    <= state_n;
      curr_floor <= floor_n;
      pending    <= (pending | floor_req) & ~clr;
      dir        <= dir_n;
      timer      <= timer_n;
    end
  end

  always_comb begin
    state_n = state_q;
    floor_n = curr_floor;
    timer_n = timer;
    dir_n   = dir;
    clr     = '0;
    case (state_q)
      S_IDLE: begin
        if (|pending)
          state_n = S_DECIDE;
      end
      S_DECIDE: begin
        if (here) begin
          state_n = S_OPEN;
          clr     = sel;
        end else if (dir && above) begin
          state_n = S_UP;
        end else if (!dir && below) begin
          state_n = S_DOWN;
        end else if (above) begin
          state_n = S_UP;
          dir_n   = 1'b1;
        end else if (below) begin
          state_n = S_DOWN;
          dir_n   = 1'b0;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_UP: begin
        if (curr_floor == TOP) begin
          state_n = S_DECIDE;
        end else if (tick1hz) begin
          if (timer == MOVE_LAST) begin
            floor_n = curr_floor + FW'(1);
            state_n = S_DECIDE;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
      end
      S_DOWN: begin
        if (curr_floor == '0) begin
          state_n = S_DECIDE;
        end else if (tick1hz) begin
          if (timer == MOVE_LAST) begin
            floor_n = curr_floor - FW'(1);
            state_n = S_DECIDE;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
      end
      S_OPEN: begin
        // a new call for this floor keeps the door open
        if (door_hold || req_here) begin
          timer_n = '0;
          if (req_here)
            clr = sel;
        end else if (door_close) begin
          state_n = S_DECIDE;
        end else if (tick1hz) begin
          if (timer == OPEN_LAST)
            state_n = S_DECIDE;
          else
            timer_n = timer + TW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (state_n != state_q)
      timer_n = '0;
  end

  always_comb begin
    running_state = RS_IDLE;
    door_state    = DS_CLOSE;
    case (state_q)
      S_UP:     running_state = RS_UP;
      S_DOWN:   running_state = RS_DOWN;
      S_DECIDE: running_state = dir ? RS_UP : RS_DOWN;
      S_OPEN: begin
        running_state = dir ? RS_UP : RS_DOWN;
        door_state    = DS_OPEN;
      end
      default:  running_state = RS_IDLE;
    endcase
  end

  assign state = state_q;

endmodule
